// File: rtl/rs_issue_select.sv
// rs_issue_select: issue side of the reservation-station array.
// Reads the per-entry fields held in storage and picks the oldest entry whose
// operands are both ready. That entry goes into a registered valid/ready issue
// slot toward the functional unit. For each issued entry, storage gets a
// one-cycle one-hot free pulse. Relative entry age is tracked in an NxN matrix.
//
// Optional feature: define RS_CDB_BYPASS_EN to let a matching CDB broadcast
// wake an operand and supply its value in the same cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   branch_mispredict   flush: drops the issue slot, clears age and free history
//   rs_we               allocation pulses, the same vector storage receives
//   busy_rs             entry occupied
//   ent_rs1/2_rdy       per-entry operand ready bits
//   ent_rs1/2_tag       per-entry operand producer tags
//   ent_rs1/2_val       per-entry operand values
//   ent_op, ent_rd_tag  per-entry opcode and destination tag
//   cdb_valid/tag/data  common data bus broadcast (used only with the bypass)
//   rs_to_free          combinational one-hot free pulse for the issued entry
//   iss_valid/iss_ready issue-slot handshake
//   iss_op/a/b/rd_tag   captured fields of the issued entry
//   iss_entry           index of the issued entry
module rs_issue_select #(
   parameter int unsigned NUM_RS = 4,
   parameter int unsigned TAG_W  = 6,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            branch_mispredict,
   input  logic [NUM_RS-1:0]               rs_we,
   input  logic [NUM_RS-1:0]               busy_rs,
   input  logic [NUM_RS-1:0]               ent_rs1_rdy,
   input  logic [NUM_RS-1:0]               ent_rs2_rdy,
   input  logic [NUM_RS-1:0][TAG_W-1:0]    ent_rs1_tag,
   input  logic [NUM_RS-1:0][TAG_W-1:0]    ent_rs2_tag,
   input  logic [NUM_RS-1:0][DATA_W-1:0]   ent_rs1_val,
   input  logic [NUM_RS-1:0][DATA_W-1:0]   ent_rs2_val,
   input  logic [NUM_RS-1:0][OP_W-1:0]     ent_op,
   input  logic [NUM_RS-1:0][TAG_W-1:0]    ent_rd_tag,
   input  logic                            cdb_valid,
   input  logic [TAG_W-1:0]                cdb_tag,
   input  logic [DATA_W-1:0]               cdb_data,
   output logic [NUM_RS-1:0]               rs_to_free,
   output logic                            iss_valid,
   input  logic                            iss_ready,
   output logic [OP_W-1:0]                 iss_op,
   output logic [DATA_W-1:0]               iss_a,
   output logic [DATA_W-1:0]               iss_b,
   output logic [TAG_W-1:0]                iss_rd_tag,
   output logic [$clog2(NUM_RS)-1:0]       iss_entry
);

   localparam int unsigned IDX_W = $clog2(NUM_RS);

   // older_q[i][j] = 1 means entry j is older than entry i
   logic [NUM_RS-1:0][NUM_RS-1:0] older_q, older_d;
   logic [NUM_RS-1:0]             free_q;
   logic [NUM_RS-1:0]             op1_rdy, op2_rdy;
   logic [NUM_RS-1:0]             use_cdb1, use_cdb2;
   logic [NUM_RS-1:0]             cand, win;
   logic                          win_any, cap;
   logic [IDX_W-1:0]              win_idx;
   logic [OP_W-1:0]               sel_op;
   logic [DATA_W-1:0]             sel_a, sel_b;
   logic [TAG_W-1:0]              sel_rd;

   // Operand readiness, optionally woken directly by the CDB
`ifdef RS_CDB_BYPASS_EN
   always_comb begin
      use_cdb1 = '0;
      use_cdb2 = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         use_cdb1[i] = cdb_valid & (ent_rs1_tag[i] == cdb_tag) & ~ent_rs1_rdy[i];
         use_cdb2[i] = cdb_valid & (ent_rs2_tag[i] == cdb_tag) & ~ent_rs2_rdy[i];
      end
   end
`else
   logic unused_cdb;
   assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_data, ent_rs1_tag, ent_rs2_tag};
   assign use_cdb1   = '0;
   assign use_cdb2   = '0;
`endif

   assign op1_rdy = ent_rs1_rdy | use_cdb1;
   assign op2_rdy = ent_rs2_rdy | use_cdb2;

   // free_q masks an entry during the cycle before storage drops its busy bit
   assign cand = busy_rs & op1_rdy & op2_rdy & ~free_q;
   assign cap  = ~iss_valid | iss_ready;

   // Oldest-ready select: a candidate wins when no older candidate exists
   always_comb begin
      win = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         win[i] = cand[i] & ~(|(older_q[i] & cand));
      end
   end

   assign win_any    = |win;
   assign rs_to_free = (cap & ~branch_mispredict & ~rst) ? win : '0;

   // One-hot winner to index and field mux
   always_comb begin
      win_idx = '0;
      sel_op  = '0;
      sel_a   = '0;
      sel_b   = '0;
      sel_rd  = '0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (win[i]) begin
            win_idx = IDX_W'(i);
            sel_op  = ent_op[i];
            sel_a   = use_cdb1[i] ? cdb_data : ent_rs1_val[i];
            sel_b   = use_cdb2[i] ? cdb_data : ent_rs2_val[i];
            sel_rd  = ent_rd_tag[i];
         end
      end
   end

   // Age matrix update: a new entry is younger than every resident entry.
   // Same-cycle allocations are ordered by index, lower index older.
   always_comb begin
      older_d = older_q;
      if (branch_mispredict) begin
         older_d = '0;
      end else begin
         for (int i = 0; i < NUM_RS; i++) begin
            for (int j = 0; j < NUM_RS; j++) begin
               if (rs_we[i]) begin
                  older_d[i][j] = (busy_rs[j] & ~rs_we[j]) | (rs_we[j] & (j < i));
               end else begin
                  older_d[i][j] = older_q[i][j] & ~rs_we[j];
               end
            end
         end
      end
   end

   // Age, free history and issue register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         older_q    <= '0;
         free_q     <= '0;
         iss_valid  <= 1'b0;
         iss_op     <= '0;
         iss_a      <= '0;
         iss_b      <= '0;
         iss_rd_tag <= '0;
         iss_entry  <= '0;
      end else begin
         older_q <= older_d;
         free_q  <= rs_to_free;
         if (branch_mispredict) begin
            iss_valid <= 1'b0;
         end else if (cap) begin
            iss_valid <= win_any;
            if (win_any) begin
               iss_op     <= sel_op;
               iss_a      <= sel_a;
               iss_b      <= sel_b;
               iss_rd_tag <= sel_rd;
               iss_entry  <= win_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_select.sv
// tb_rs_issue_select: directed scenarios plus randomized traffic.
// The bench emulates reservation-station storage around the DUT. It also keeps
// an age-by-sequence-number reference model of oldest-ready issue.
module tb_rs_issue_select;

   localparam int unsigned NUM_RS = 4;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned IDX_W  = 2;
`ifdef RS_CDB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          branch_mispredict;
   logic [NUM_RS-1:0]             rs_we, busy_rs, ent_rs1_rdy, ent_rs2_rdy;
   logic [NUM_RS-1:0][TAG_W-1:0]  ent_rs1_tag, ent_rs2_tag, ent_rd_tag;
   logic [NUM_RS-1:0][DATA_W-1:0] ent_rs1_val, ent_rs2_val;
   logic [NUM_RS-1:0][OP_W-1:0]   ent_op;
   logic                          cdb_valid;
   logic [TAG_W-1:0]              cdb_tag;
   logic [DATA_W-1:0]             cdb_data;
   logic [NUM_RS-1:0]             rs_to_free;
   logic                          iss_valid, iss_ready;
   logic [OP_W-1:0]               iss_op;
   logic [DATA_W-1:0]             iss_a, iss_b;
   logic [TAG_W-1:0]              iss_rd_tag;
   logic [IDX_W-1:0]              iss_entry;

   // staged allocation payloads, written into storage at the edge
   logic [NUM_RS-1:0][OP_W-1:0]   st_op;
   logic [NUM_RS-1:0][DATA_W-1:0] st_a, st_b;
   logic [NUM_RS-1:0][TAG_W-1:0]  st_rd, st_t1, st_t2;
   logic [NUM_RS-1:0]             st_r1, st_r2;

   // reference model state
   int                seq [NUM_RS];
   int                seq_ctr;
   logic [NUM_RS-1:0] pending, exp_free, obs_free;
   logic              m_valid;
   logic [OP_W-1:0]   m_op;
   logic [DATA_W-1:0] m_a, m_b;
   logic [TAG_W-1:0]  m_rd;
   logic [IDX_W-1:0]  m_entry;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rs_issue_select #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
      .rs_we(rs_we), .busy_rs(busy_rs),
      .ent_rs1_rdy(ent_rs1_rdy), .ent_rs2_rdy(ent_rs2_rdy),
      .ent_rs1_tag(ent_rs1_tag), .ent_rs2_tag(ent_rs2_tag),
      .ent_rs1_val(ent_rs1_val), .ent_rs2_val(ent_rs2_val),
      .ent_op(ent_op), .ent_rd_tag(ent_rd_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rs_to_free(rs_to_free), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
      .iss_rd_tag(iss_rd_tag), .iss_entry(iss_entry)
   );

   function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
      return BYPASS && cdb_valid && (t == cdb_tag);
   endfunction

   task automatic reset_model();
      busy_rs = '0; ent_rs1_rdy = '0; ent_rs2_rdy = '0; rs_we = '0;
      pending = '0; m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0;
      m_rd = '0; m_entry = '0; seq_ctr = 0;
      for (int i = 0; i < NUM_RS; i++) seq[i] = 0;
   endtask

   task automatic alloc(input int idx, input logic [OP_W-1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [TAG_W-1:0] rd, input logic r1, input logic r2,
                        input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
      rs_we[idx] = 1'b1; st_op[idx] = op; st_a[idx] = a; st_b[idx] = b;
      st_rd[idx] = rd; st_r1[idx] = r1; st_r2[idx] = r2;
      st_t1[idx] = t1; st_t2[idx] = t2;
   endtask

   // One clock: predict issue, advance the model and storage, end at negedge
   task automatic cycle();
      int               win;
      logic             cap;
      logic [OP_W-1:0]  n_op;
      logic [DATA_W-1:0] n_a, n_b;
      logic [TAG_W-1:0] n_rd;
      logic [IDX_W-1:0] wi;
      #1;
      obs_free = rs_to_free;
      win = -1;
      for (int i = 0; i < NUM_RS; i++) begin
         if (busy_rs[i] && !pending[i] &&
             (ent_rs1_rdy[i] || cdb_hit(ent_rs1_tag[i])) &&
             (ent_rs2_rdy[i] || cdb_hit(ent_rs2_tag[i])))
            if (win < 0 || seq[i] < seq[win]) win = i;
      end
      cap = !m_valid || iss_ready;
      exp_free = '0;
      wi = '0; n_op = '0; n_a = '0; n_b = '0; n_rd = '0;
      if (win >= 0) begin
         wi   = IDX_W'(win);
         n_op = ent_op[wi];
         n_a  = (!ent_rs1_rdy[wi] && cdb_hit(ent_rs1_tag[wi])) ? cdb_data : ent_rs1_val[wi];
         n_b  = (!ent_rs2_rdy[wi] && cdb_hit(ent_rs2_tag[wi])) ? cdb_data : ent_rs2_val[wi];
         n_rd = ent_rd_tag[wi];
      end
      if (cap && !branch_mispredict && win >= 0) exp_free[wi] = 1'b1;
      @(posedge clk);
      #1;
      if (branch_mispredict) m_valid = 1'b0;
      else if (cap) begin
         m_valid = (win >= 0);
         if (win >= 0) begin
            m_op = n_op; m_a = n_a; m_b = n_b; m_rd = n_rd; m_entry = wi;
         end
      end
      if (branch_mispredict) begin
         busy_rs = '0; pending = '0;
      end else begin
         busy_rs = busy_rs & ~pending;
         pending = exp_free;
         for (int i = 0; i < NUM_RS; i++) begin
            if (rs_we[i]) begin
               busy_rs[i] = 1'b1; ent_op[i] = st_op[i];
               ent_rs1_val[i] = st_a[i]; ent_rs2_val[i] = st_b[i];
               ent_rd_tag[i] = st_rd[i]; ent_rs1_rdy[i] = st_r1[i];
               ent_rs2_rdy[i] = st_r2[i]; ent_rs1_tag[i] = st_t1[i];
               ent_rs2_tag[i] = st_t2[i];
               seq[i] = seq_ctr; seq_ctr++;
            end
         end
      end
      rs_we = '0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      iss_ready = 1'b1;
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      reset_model();
      iss_ready = 1'b1;
      busy_rs[0] = 1'b1; ent_rs1_rdy[0] = 1'b1; ent_rs2_rdy[0] = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rs_to_free !== 4'b0000) begin
         n_errors++; $display("FAIL reset_free: got %b expected 0000", rs_to_free);
      end
      n_checks++;
      if ({iss_valid, iss_op, iss_a, iss_b, iss_rd_tag, iss_entry} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h rd=%h e=%h expected all 0",
                  iss_valid, iss_op, iss_a, iss_b, iss_rd_tag, iss_entry);
      end
      reset_model();
      rst = 1'b0;
      cycle();
      n_checks++;
      if (iss_valid !== 1'b0) begin
         n_errors++; $display("FAIL reset_idle_valid: got %b expected 0", iss_valid);
      end
   endtask

   task automatic test_single_issue();
      iss_ready = 1'b1;
      alloc(2, 4'd3, 32'h11, 32'h22, 6'd5, 1'b1, 1'b1, 6'd1, 6'd2);
      cycle();
      cycle();
      n_checks++;
      if (obs_free !== 4'b0100) begin
         n_errors++; $display("FAIL single_free: got %b expected 0100", obs_free);
      end
      n_checks++;
      if ({iss_valid, iss_op, iss_a, iss_b, iss_rd_tag, iss_entry} !==
          {1'b1, 4'd3, 32'h11, 32'h22, 6'd5, 2'd2}) begin
         n_errors++;
         $display("FAIL single_issue: got v=%b op=%h a=%h b=%h rd=%h e=%h expected v=1 op=3 a=11 b=22 rd=5 e=2",
                  iss_valid, iss_op, iss_a, iss_b, iss_rd_tag, iss_entry);
      end
      idle(3);
   endtask

   task automatic test_age_order();
      alloc(3, 4'd1, 32'h30, 32'h31, 6'd13, 1'b0, 1'b0, 6'd20, 6'd21);
      cycle();
      alloc(0, 4'd2, 32'h40, 32'h41, 6'd10, 1'b0, 1'b0, 6'd22, 6'd23);
      cycle();
      ent_rs1_rdy = 4'b1001; ent_rs2_rdy = 4'b1001;
      cycle();
      n_checks++;
      if (obs_free !== 4'b1000 || iss_entry !== 2'd3 || iss_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL age_first: got free=%b e=%0d v=%b expected free=1000 e=3 v=1",
                  obs_free, iss_entry, iss_valid);
      end
      cycle();
      n_checks++;
      if (obs_free !== 4'b0001 || iss_entry !== 2'd0 || iss_a !== 32'h40) begin
         n_errors++;
         $display("FAIL age_second: got free=%b e=%0d a=%h expected free=0001 e=0 a=40",
                  obs_free, iss_entry, iss_a);
      end
      idle(3);
   endtask

   task automatic test_same_cycle_alloc();
      alloc(1, 4'd6, 32'h51, 32'h52, 6'd11, 1'b1, 1'b1, 6'd0, 6'd0);
      alloc(0, 4'd7, 32'h61, 32'h62, 6'd12, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      cycle();
      n_checks++;
      if (obs_free !== 4'b0001 || iss_entry !== 2'd0) begin
         n_errors++;
         $display("FAIL same_cycle_first: got free=%b e=%0d expected free=0001 e=0", obs_free, iss_entry);
      end
      cycle();
      n_checks++;
      if (obs_free !== 4'b0010 || iss_entry !== 2'd1 || iss_op !== 4'd6) begin
         n_errors++;
         $display("FAIL same_cycle_second: got free=%b e=%0d op=%h expected free=0010 e=1 op=6",
                  obs_free, iss_entry, iss_op);
      end
      idle(3);
   endtask

   task automatic test_stall();
      iss_ready = 1'b0;
      alloc(0, 4'd1, 32'hA0, 32'hA1, 6'd7, 1'b1, 1'b1, 6'd0, 6'd0);
      alloc(1, 4'd2, 32'hB0, 32'hB1, 6'd8, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      cycle();
      n_checks++;
      if (obs_free !== 4'b0001 || iss_valid !== 1'b1 || iss_a !== 32'hA0) begin
         n_errors++;
         $display("FAIL stall_first: got free=%b v=%b a=%h expected free=0001 v=1 a=a0",
                  obs_free, iss_valid, iss_a);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_checks++;
         if (obs_free !== 4'b0000 || iss_valid !== 1'b1 || iss_a !== 32'hA0 ||
             iss_b !== 32'hA1 || iss_entry !== 2'd0 || iss_rd_tag !== 6'd7) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got free=%b v=%b a=%h b=%h e=%0d rd=%0d expected free=0000 v=1 a=a0 b=a1 e=0 rd=7",
                     k, obs_free, iss_valid, iss_a, iss_b, iss_entry, iss_rd_tag);
         end
      end
      iss_ready = 1'b1;
      cycle();
      n_checks++;
      if (obs_free !== 4'b0010 || iss_entry !== 2'd1 || iss_a !== 32'hB0) begin
         n_errors++;
         $display("FAIL stall_release: got free=%b e=%0d a=%h expected free=0010 e=1 a=b0",
                  obs_free, iss_entry, iss_a);
      end
      idle(3);
   endtask

   task automatic test_flush();
      iss_ready = 1'b0;
      alloc(2, 4'd4, 32'h33, 32'h34, 6'd3, 1'b1, 1'b1, 6'd0, 6'd0);
      alloc(3, 4'd5, 32'h43, 32'h44, 6'd4, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      cycle();
      cycle();
      branch_mispredict = 1'b1;
      alloc(0, 4'd9, 32'h99, 32'h98, 6'd9, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      branch_mispredict = 1'b0;
      n_checks++;
      if (obs_free !== 4'b0000 || iss_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush: got free=%b v=%b expected free=0000 v=0", obs_free, iss_valid);
      end
      iss_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_checks++;
         if (obs_free !== 4'b0000 || iss_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_quiet[%0d]: got free=%b v=%b expected free=0000 v=0", k, obs_free, iss_valid);
         end
      end
      alloc(1, 4'd8, 32'h77, 32'h78, 6'd2, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      cycle();
      n_checks++;
      if (obs_free !== 4'b0010 || iss_valid !== 1'b1 || iss_a !== 32'h77) begin
         n_errors++;
         $display("FAIL flush_realloc: got free=%b v=%b a=%h expected free=0010 v=1 a=77",
                  obs_free, iss_valid, iss_a);
      end
      idle(3);
   endtask

   task automatic test_cdb_bypass();
      alloc(1, 4'd5, 32'h5, 32'h0, 6'd4, 1'b1, 1'b0, 6'd2, 6'd9);
      cycle();
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hABCD;
      cycle();
      cdb_valid = 1'b0;
`ifdef RS_CDB_BYPASS_EN
      n_checks++;
      if (obs_free !== 4'b0010 || iss_valid !== 1'b1 || iss_b !== 32'hABCD || iss_a !== 32'h5) begin
         n_errors++;
         $display("FAIL cdb_bypass: got free=%b v=%b a=%h b=%h expected free=0010 v=1 a=5 b=abcd",
                  obs_free, iss_valid, iss_a, iss_b);
      end
`else
      n_checks++;
      if (obs_free !== 4'b0000 || iss_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL cdb_no_bypass: got free=%b v=%b expected free=0000 v=0", obs_free, iss_valid);
      end
      ent_rs2_rdy[1] = 1'b1; ent_rs2_val[1] = 32'hABCD;
      cycle();
      n_checks++;
      if (obs_free !== 4'b0010 || iss_b !== 32'hABCD) begin
         n_errors++;
         $display("FAIL cdb_wakeup: got free=%b b=%h expected free=0010 b=abcd", obs_free, iss_b);
      end
`endif
      idle(3);
   endtask

   task automatic test_async_reset();
      iss_ready = 1'b0;
      alloc(0, 4'd2, 32'h12, 32'h13, 6'd1, 1'b1, 1'b1, 6'd0, 6'd0);
      cycle();
      cycle();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (iss_valid !== 1'b0 || rs_to_free !== 4'b0000) begin
         n_errors++;
         $display("FAIL async_reset: got v=%b free=%b expected v=0 free=0000", iss_valid, rs_to_free);
      end
      reset_model();
      @(negedge clk);
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_random();
      int k;
      for (int n = 0; n < 600; n++) begin
         iss_ready = ($urandom_range(0, 3) != 0);
         branch_mispredict = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NUM_RS; i++) begin
            if (!busy_rs[i] && $urandom_range(0, 2) == 0)
               alloc(i, OP_W'($urandom), $urandom, $urandom, TAG_W'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     TAG_W'($urandom), TAG_W'($urandom));
            else if (busy_rs[i] && $urandom_range(0, 3) == 0) begin
               ent_rs1_rdy[i] = ent_rs1_rdy[i] | 1'($urandom_range(0, 1));
               ent_rs2_rdy[i] = ent_rs2_rdy[i] | 1'($urandom_range(0, 1));
            end
         end
         k = $urandom_range(0, NUM_RS - 1);
         cdb_valid = ($urandom_range(0, 2) == 0);
         cdb_tag   = $urandom_range(0, 1) ? ent_rs2_tag[k] : ent_rs1_tag[k];
         cdb_data  = $urandom;
         cycle();
         n_checks++;
         if (obs_free !== exp_free) begin
            n_errors++; $display("FAIL rand_free[%0d]: got %b expected %b", n, obs_free, exp_free);
         end
         n_checks++;
         if (iss_valid !== m_valid) begin
            n_errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, iss_valid, m_valid);
         end else if (m_valid) begin
            n_checks++;
            if ({iss_op, iss_a, iss_b, iss_rd_tag, iss_entry} !== {m_op, m_a, m_b, m_rd, m_entry}) begin
               n_errors++;
               $display("FAIL rand_fields[%0d]: got op=%h a=%h b=%h rd=%h e=%0d expected op=%h a=%h b=%h rd=%h e=%0d",
                        n, iss_op, iss_a, iss_b, iss_rd_tag, iss_entry, m_op, m_a, m_b, m_rd, m_entry);
            end
         end
      end
      branch_mispredict = 1'b0;
      cdb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; branch_mispredict = 1'b0; iss_ready = 1'b1;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      ent_rs1_tag = '0; ent_rs2_tag = '0; ent_rd_tag = '0;
      ent_rs1_val = '0; ent_rs2_val = '0; ent_op = '0;
      st_op = '0; st_a = '0; st_b = '0; st_rd = '0; st_t1 = '0; st_t2 = '0;
      st_r1 = '0; st_r2 = '0; exp_free = '0; obs_free = '0;
      reset_model();
      test_reset();
      test_single_issue();
      test_age_order();
      test_same_cycle_alloc();
      test_stall();
      test_flush();
      test_cdb_bypass();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
